// File: rtl/sound_event_seq.sv
// sound_event_seq: turns single-cycle pong game events into timed,
// non-overlapping beep requests for the tone generator. Each beep is
// followed by a silent gap. Events that arrive while busy wait in one
// pending slot per event type and are served score > paddle > wall.
module sound_event_seq #(
   parameter int unsigned DUR_WALL   = 2_500_000,
   parameter int unsigned DUR_PADDLE = 5_000_000,
   parameter int unsigned DUR_SCORE  = 20_000_000,
   parameter int unsigned GAP        = 1_000_000,
   parameter int unsigned CNT_W      = 25
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit_wall,
   input  logic       hit_paddle,
   input  logic       score,
   input  logic       mute,
   output logic       snd_en,
   output logic [1:0] tone_sel,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   // Counter reload values: the counter runs from N-1 down to 0, so each
   // phase lasts exactly N cycles.
   localparam logic [CNT_W-1:0] LD_WALL   = CNT_W'(DUR_WALL - 1);
   localparam logic [CNT_W-1:0] LD_PADDLE = CNT_W'(DUR_PADDLE - 1);
   localparam logic [CNT_W-1:0] LD_SCORE  = CNT_W'(DUR_SCORE - 1);
   localparam logic [CNT_W-1:0] LD_GAP    = CNT_W'(GAP - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // pend bit 0 = wall, bit 1 = paddle, bit 2 = score
   logic [2:0]       pend_q, pend_d;
   logic             snd_en_q, snd_en_d;
   logic [1:0]       tone_q, tone_d;
   logic             busy_q, busy_d;

   logic [2:0]       ev;
   logic [2:0]       cand;

   // Same-cycle pulses are merged with the pending slots; duplicates collapse.
   assign ev   = {score, hit_paddle, hit_wall};
   assign cand = pend_q | ev;

   // Next-state, pending latch, counter and registered-output computation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pend_d   = pend_q;
      snd_en_d = snd_en_q;
      tone_d   = tone_q;
      busy_d   = busy_q;
      if (mute) begin
         // Mute overrides everything and flushes queued events.
         state_d  = ST_IDLE;
         cnt_d    = '0;
         pend_d   = '0;
         snd_en_d = 1'b0;
         tone_d   = 2'd0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               snd_en_d = 1'b0;
               tone_d   = 2'd0;
               busy_d   = 1'b0;
               pend_d   = cand;
               if (cand != 3'b000) begin
                  // Launch the highest-priority source; clearing its slot here
                  // also swallows a same-type pulse arriving on this edge.
                  state_d  = ST_PLAY;
                  snd_en_d = 1'b1;
                  busy_d   = 1'b1;
                  if (cand[2]) begin
                     tone_d = 2'd3;
                     cnt_d  = LD_SCORE;
                     pend_d = cand & 3'b011;
                  end else if (cand[1]) begin
                     tone_d = 2'd2;
                     cnt_d  = LD_PADDLE;
                     pend_d = cand & 3'b101;
                  end else begin
                     tone_d = 2'd1;
                     cnt_d  = LD_WALL;
                     pend_d = cand & 3'b110;
                  end
               end
            end
            ST_PLAY: begin
               pend_d = cand;
               if (cnt_q == '0) begin
                  state_d  = ST_GAP;
                  cnt_d    = LD_GAP;
                  snd_en_d = 1'b0;
                  tone_d   = 2'd0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            ST_GAP: begin
               pend_d = cand;
               if (cnt_q == '0) begin
                  // Return to IDLE for one cycle; a queued beep launches from there.
                  state_d = ST_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  cnt_d = cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               pend_d   = '0;
               snd_en_d = 1'b0;
               tone_d   = 2'd0;
               busy_d   = 1'b0;
            end
         endcase
      end
   end

   // State, counter, pending slots and outputs, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         pend_q   <= '0;
         snd_en_q <= 1'b0;
         tone_q   <= 2'd0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pend_q   <= pend_d;
         snd_en_q <= snd_en_d;
         tone_q   <= tone_d;
         busy_q   <= busy_d;
      end
   end

   assign snd_en   = snd_en_q;
   assign tone_sel = tone_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_sound_event_seq.sv
// tb_sound_event_seq: directed scenarios with literal expectations plus a
// randomized phase, all continuously compared against a behavioural model.
module tb_sound_event_seq;

   localparam int DW = 4;
   localparam int DP = 6;
   localparam int DS = 10;
   localparam int DG = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       hit_wall = 1'b0;
   logic       hit_paddle = 1'b0;
   logic       score = 1'b0;
   logic       mute = 1'b0;
   logic       snd_en;
   logic [1:0] tone_sel;
   logic       busy;

   int vec_cnt = 0;
   int err_cnt = 0;
   bit cmp_on = 1'b0;

   always #5 clk = ~clk;

   sound_event_seq #(
      .DUR_WALL  (DW),
      .DUR_PADDLE(DP),
      .DUR_SCORE (DS),
      .GAP       (DG),
      .CNT_W     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .hit_wall  (hit_wall),
      .hit_paddle(hit_paddle),
      .score     (score),
      .mute      (mute),
      .snd_en    (snd_en),
      .tone_sel  (tone_sel),
      .busy      (busy)
   );

   // ---------------- behavioural model ----------------
   // play  = cycles of tone still to emit (including the current one)
   // quiet = silent busy cycles still to emit
   typedef struct packed {
      int         play;
      int         quiet;
      int         tone;
      logic [2:0] pend;
   } mstate_t;

   mstate_t m;

   function automatic int dur_of(int t);
      case (t)
         1:       return DW;
         2:       return DP;
         default: return DS;
      endcase
   endfunction

   function automatic mstate_t model_next(mstate_t s, logic mu, logic [2:0] ev);
      mstate_t    n;
      logic [2:0] cand;
      n = s;
      if (mu) begin
         n = '0;
         return n;
      end
      cand = s.pend | ev;
      if (s.play > 0) begin
         n.play = s.play - 1;
         if (n.play == 0) n.quiet = DG;
         n.pend = cand;
      end else if (s.quiet > 0) begin
         n.quiet = s.quiet - 1;
         n.pend  = cand;
      end else if (cand != 3'b000) begin
         for (int k = 0; k < 3; k++) if (cand[k]) n.tone = k + 1;
         n.play = dur_of(n.tone);
         n.pend = cand & ~(3'b001 << (n.tone - 1));
      end
      return n;
   endfunction

   initial begin
      m = '0;
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) m = '0;
         else m = model_next(m, mute, {score, hit_paddle, hit_wall});
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            check("snd_en", 32'(snd_en), 32'(m.play > 0));
            check("tone_sel", 32'(tone_sel), (m.play > 0) ? 32'(m.tone) : 32'd0);
            check("busy", 32'(busy), 32'((m.play > 0) || (m.quiet > 0)));
         end
      end
   end

   // ---------------- directed helpers (called at a negedge) ----------------
   task automatic pulse(bit w, bit p, bit s);
      hit_wall = w; hit_paddle = p; score = s;
      @(negedge clk);
      hit_wall = 1'b0; hit_paddle = 1'b0; score = 1'b0;
   endtask

   task automatic expect_beep(string name, int tone, int len);
      bit ok;
      int n;
      int t;
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (snd_en) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check({name, "_start"}, 32'(ok), 32'd1);
      if (!ok) return;
      t = int'(tone_sel);
      n = 0;
      while (snd_en && n < 100) begin
         n++;
         @(negedge clk);
      end
      check({name, "_tone"}, 32'(t), 32'(tone));
      check({name, "_len"}, 32'(n), 32'(len));
   endtask

   task automatic expect_low(string name, int len);
      int n;
      n = 0;
      while (!snd_en && n < 100) begin
         n++;
         @(negedge clk);
      end
      check(name, 32'(n), 32'(len));
   endtask

   task automatic expect_silence(string name, int cycles);
      int highs;
      highs = 0;
      for (int i = 0; i < cycles; i++) begin
         if (snd_en) highs++;
         @(negedge clk);
      end
      check(name, 32'(highs), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_snd_en", 32'(snd_en), 32'd0);
      check("rst_tone_sel", 32'(tone_sel), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      cmp_on = 1'b1;
      repeat (2) @(negedge clk);

      // Single wall pulse: one-edge latency, 4 high, 3 busy-silent cycles
      pulse(1, 0, 0);
      check("wall_latency", 32'(snd_en), 32'd1);
      expect_beep("wall", 1, 4);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("wall_gap_busy", 32'(n), 32'(DG));
      expect_silence("wall_after", 10);

      // Wall during a paddle beep waits for paddle + gap
      pulse(0, 1, 0);
      fork
         begin
            expect_beep("paddle_first", 2, 6);
            expect_low("paddle_wall_gap", DG + 1);
            expect_beep("wall_queued", 1, 4);
         end
         begin
            repeat (2) @(negedge clk);
            pulse(1, 0, 0);
         end
      join
      expect_silence("queue_after", 12);

      // All three at once: score, paddle, wall
      pulse(1, 1, 1);
      expect_beep("tri_score", 3, 10);
      expect_low("tri_gap1", DG + 1);
      expect_beep("tri_paddle", 2, 6);
      expect_low("tri_gap2", DG + 1);
      expect_beep("tri_wall", 1, 4);
      expect_silence("tri_after", 12);

      // Three paddle pulses during a score beep collapse to one beep
      pulse(0, 0, 1);
      fork
         begin
            expect_beep("coll_score", 3, 10);
            expect_low("coll_gap", DG + 1);
            expect_beep("coll_paddle", 2, 6);
            expect_silence("coll_no_dup", 30);
         end
         begin
            repeat (2) @(negedge clk);
            pulse(0, 1, 0);
            repeat (2) @(negedge clk);
            pulse(0, 1, 0);
            repeat (3) @(negedge clk);
            pulse(0, 1, 0);
         end
      join

      // Mute mid-beep with wall pending
      pulse(0, 1, 0);
      repeat (2) @(negedge clk);
      pulse(1, 0, 0);
      mute = 1'b1;
      @(negedge clk);
      check("mute_snd_en", 32'(snd_en), 32'd0);
      check("mute_busy", 32'(busy), 32'd0);
      check("mute_tone", 32'(tone_sel), 32'd0);
      pulse(1, 0, 1);
      repeat (2) @(negedge clk);
      mute = 1'b0;
      expect_silence("mute_flushed", 30);
      pulse(1, 0, 0);
      expect_beep("post_mute_wall", 1, 4);
      expect_silence("post_mute_after", 10);

      // Asynchronous reset mid-beep
      pulse(0, 0, 1);
      repeat (3) @(negedge clk);
      check("pre_rst_snd_en", 32'(snd_en), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_snd_en", 32'(snd_en), 32'd0);
      check("async_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse(1, 0, 0);
      expect_beep("post_rst_wall", 1, 4);
      expect_silence("post_rst_after", 10);

      // Randomized phase: sparse then dense events, occasional mute bursts
      for (int seg = 0; seg < 2; seg++) begin
         int rate;
         rate = (seg == 0) ? 3 : 15;
         for (int c = 0; c < 3000; c++) begin
            hit_wall   = ($urandom_range(0, 99) < rate);
            hit_paddle = ($urandom_range(0, 99) < rate);
            score      = ($urandom_range(0, 99) < rate);
            if (mute) mute = ($urandom_range(0, 3) != 0);
            else      mute = ($urandom_range(0, 299) == 0);
            @(negedge clk);
         end
      end
      hit_wall = 1'b0; hit_paddle = 1'b0; score = 1'b0; mute = 1'b0;
      repeat (40) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/sound_event_seq.md
Name: sound_event_seq

Overview:
- Upstream sequencer for the tone generator.
- Takes single-cycle game-event pulses from the pong game logic: wall bounce, paddle hit, point scored.
- Turns them into timed, non-overlapping beep requests. It drives the generator's enable level, selects the beep type, and enforces a silent gap between beeps.
- Events arriving while a beep plays are queued, one slot per event type, and served by fixed priority.

Parameters:
- DUR_WALL, 2_500_000, cycles snd_en stays high for a wall beep (25 ms at 100 MHz).
- DUR_PADDLE, 5_000_000, cycles high for a paddle beep.
- DUR_SCORE, 20_000_000, cycles high for a score beep.
- GAP, 1_000_000, cycles snd_en is forced low between consecutive beeps.
- CNT_W, 25, width of the internal duration/gap counter. Must hold max(DUR_*, GAP).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- hit_wall  in  1  one-cycle pulse: ball hit top or bottom wall.
- hit_paddle  in  1  one-cycle pulse: ball hit a paddle.
- score  in  1  one-cycle pulse: point scored.
- mute  in  1  level; high silences and flushes everything.
- snd_en  out  1  enable to the tone generator; high for exactly the beep duration.
- tone_sel  out  2  0 = none, 1 = wall, 2 = paddle, 3 = score; valid while snd_en is high.
- busy  out  1  high in PLAY or GAP state.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE, counter = 0, pending[2:0] = 0.
  - snd_en = 0, tone_sel = 0, busy = 0.
- All outputs are registered.
- States:
  - IDLE: snd_en = 0, tone_sel = 0.
  - PLAY: snd_en = 1, tone_sel = current type.
  - GAP: snd_en = 0, tone_sel = 0.
- Pending latch:
  - Each event pulse sets its pending bit on the clock edge, unless mute is high.
  - Repeated pulses of the same type collapse into one.
  - A bit clears when its beep is launched.
- Priority: score > paddle > wall.
- IDLE -> PLAY:
  - Taken when any pending bit is set, or any event input is high this cycle.
  - Same-cycle events are considered together with pending bits.
  - The highest-priority source is chosen, its pending bit is cleared, counter is loaded with DUR_x-1, and tone_sel is set.
  - Latency: a pulse sampled at edge N in IDLE gives snd_en = 1 after edge N.
- PLAY:
  - Counter decrements each cycle.
  - At counter = 0, go to GAP and load counter with GAP-1.
  - snd_en is therefore high for exactly DUR_x cycles.
  - No preemption: a score arriving during a wall beep waits in pending.
- GAP:
  - Counter decrements each cycle.
  - At counter = 0, go to IDLE.
  - If pending is non-zero, launch the next beep the cycle after returning to IDLE.
  - Result: exactly GAP low cycles plus 1 IDLE cycle between beeps. Bench checks GAP+1.
- An event pulse on the same edge that its own pending bit is cleared at launch is absorbed; no duplicate beep.
- Simultaneous pulses of different types: all are latched, then served in priority order.
- mute high, in any state:
  - Next edge: state = IDLE, pending = 0, snd_en = 0, tone_sel = 0.
  - Events are ignored while mute is high.
  - After mute falls, sequencing resumes on the next new event.
- rst asserted mid-beep: outputs go low immediately (asynchronous), without waiting for a clock edge.
- Counter never wraps; it is only decremented in PLAY or GAP, and only while it is non-zero.

Test Plan (DUR_WALL=4, DUR_PADDLE=6, DUR_SCORE=10, GAP=3):
- Single hit_wall pulse in IDLE at edge N:
  - snd_en high edges N+1..N+4 with tone_sel=1.
  - Low from N+5; busy low from N+8.
- hit_wall during a paddle beep:
  - Paddle beep runs its full 6 cycles, then 4 low cycles.
  - Then a 4-cycle wall beep, tone_sel=1.
- hit_wall, hit_paddle and score pulsed in the same cycle from IDLE:
  - Beeps play in order score(10), paddle(6), wall(4), each separated by 4 low cycles.
- Three hit_paddle pulses during a score beep:
  - Exactly one paddle beep follows; no second beep.
- mute raised mid-beep with wall pending:
  - snd_en = 0 and busy = 0 on the next edge.
  - After mute falls, no beep plays until a new pulse arrives.
- rst pulled low mid-beep:
  - snd_en drops before the next clock edge.
  - After release, a hit_wall gives a normal 4-cycle beep.
